// File: rtl/sop_tap_loader.sv
`default_nettype none
// ============================================================================
// Module      : sop_tap_loader
// Description : Upstream feeder for the 4-tap sum-of-products datapath.
//               Accepts a valid/ready sample stream into a 4-deep delay line
//               (d1 newest .. d4 oldest), holds double-buffered coefficients
//               (shadow slots -> active c1..c4 on commit) and pulses
//               taps_valid when a freshly shifted, fully populated tap set is
//               presented.
// Configuration macro:
//   COEF_LOCK_EN : when defined, coef_we / coef_commit are ignored in RUN so
//                  every tap set produced in RUN uses one coefficient set.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   coef_we/addr/data   write one shadow coefficient slot (0->c1 .. 3->c4)
//   coef_commit         copy all shadow slots to active c1..c4
//   flush               clear delay line, return to FILL (coefficients kept)
//   s_valid/s_data      sample input
//   s_ready             sample can be accepted this cycle
//   d1..d4              delay-line taps
//   c1..c4              active coefficients
//   taps_valid          1-cycle pulse: taps updated and all four are real
//   fill_count          real samples held in the line, saturates at 4
// Revision    : 1.0 - initial release
// ============================================================================
module sop_tap_loader #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coef_we,
  input  logic [1:0]       coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  input  logic             coef_commit,
  input  logic             flush,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] d4,
  output logic [WIDTH-1:0] c1,
  output logic [WIDTH-1:0] c2,
  output logic [WIDTH-1:0] c3,
  output logic [WIDTH-1:0] c4,
  output logic             taps_valid,
  output logic [2:0]       fill_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shadow [4];
  logic             w_accept;
  logic             w_coef_ok;

  assign s_ready  = (r_state != ST_IDLE) && !flush;
  assign w_accept = s_valid && s_ready;

`ifdef COEF_LOCK_EN
  // Freeze the coefficient path while tap sets are being streamed.
  assign w_coef_ok = (r_state != ST_RUN);
`else
  assign w_coef_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      d4         <= '0;
      c1         <= '0;
      c2         <= '0;
      c3         <= '0;
      c4         <= '0;
      r_shadow   <= '{default: '0};
      taps_valid <= 1'b0;
      fill_count <= 3'd0;
    end else begin
      // Pulse only when this accept completes or refreshes a full line.
      taps_valid <= w_accept && (fill_count >= 3'd3);

      // Commit reads the pre-edge shadow, so a same-edge write only lands in
      // the shadow and becomes active on a later commit.
      if (w_coef_ok && coef_we)
        r_shadow[coef_addr] <= coef_data;
      if (w_coef_ok && coef_commit) begin
        c1 <= r_shadow[0];
        c2 <= r_shadow[1];
        c3 <= r_shadow[2];
        c4 <= r_shadow[3];
      end

      case (r_state)
        ST_IDLE: begin
          if (coef_commit)
            r_state <= ST_FILL;
        end
        ST_FILL, ST_RUN: begin
          if (flush) begin
            d1         <= '0;
            d2         <= '0;
            d3         <= '0;
            d4         <= '0;
            fill_count <= 3'd0;
            r_state    <= ST_FILL;
          end else if (w_accept) begin
            d4 <= d3;
            d3 <= d2;
            d2 <= d1;
            d1 <= s_data;
            if (fill_count < 3'd4)
              fill_count <= fill_count + 3'd1;
            if (fill_count >= 3'd3)
              r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sop_tap_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sop_tap_loader
// Description : Self-checking bench for sop_tap_loader. A table of stimulus /
//               expected-output records is pushed onto a scoreboard queue as
//               each record is driven and popped after the clock edge for
//               comparison; a hand-written tail covers the multi-cycle
//               coefficient/flush interactions.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sop_tap_loader;

`ifdef COEF_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, coef_we, coef_commit, flush, s_valid, s_ready, taps_valid;
  logic [1:0] coef_addr;
  logic [3:0] coef_data, s_data, d1, d2, d3, d4, c1, c2, c3, c4;
  logic [2:0] fill_count;

  always #5 clk = ~clk;

  sop_tap_loader #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .flush(flush),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .taps_valid(taps_valid), .fill_count(fill_count)
  );

  typedef struct {
    bit        rst, we;
    bit [1:0]  addr;
    bit [3:0]  cdata;
    bit        commit, flush, valid;
    bit [3:0]  sdata;
    bit        exp_ready;   // s_ready while these inputs are applied
    bit [15:0] exp_d;       // {d1,d2,d3,d4} after the edge
    bit [15:0] exp_c;       // {c1,c2,c3,c4} after the edge
    bit        exp_tv;
    bit [2:0]  exp_fc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(bit r, bit we, bit [1:0] a, bit [3:0] cd,
                              bit cm, bit fl, bit sv, bit [3:0] sd, bit er,
                              bit [15:0] ed, bit [15:0] ec, bit tv, bit [2:0] fc);
    vec_t v;
    v.rst = r; v.we = we; v.addr = a; v.cdata = cd; v.commit = cm;
    v.flush = fl; v.valid = sv; v.sdata = sd; v.exp_ready = er;
    v.exp_d = ed; v.exp_c = ec; v.exp_tv = tv; v.exp_fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one record, check s_ready combinationally, then compare the
  // registered outputs after the edge against the scoreboard entry.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    rst = v.rst; coef_we = v.we; coef_addr = v.addr; coef_data = v.cdata;
    coef_commit = v.commit; flush = v.flush; s_valid = v.valid; s_data = v.sdata;
    #1;
    chk($sformatf("s_ready[%0d]", idx), {31'd0, s_ready}, {31'd0, v.exp_ready});
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("d[%0d]", idx), {16'd0, d1, d2, d3, d4}, {16'd0, e.exp_d});
    chk($sformatf("c[%0d]", idx), {16'd0, c1, c2, c3, c4}, {16'd0, e.exp_c});
    chk($sformatf("taps_valid[%0d]", idx), {31'd0, taps_valid}, {31'd0, e.exp_tv});
    chk($sformatf("fill_count[%0d]", idx), {29'd0, fill_count}, {29'd0, e.exp_fc});
  endtask

  initial begin
    bit [15:0] c22, c24, h4c, h6c;
    c22 = LOCK ? 16'h1234 : 16'h12F4;
    c24 = LOCK ? 16'h1234 : 16'h72F4;
    h4c = LOCK ? 16'h1534 : 16'h75F4;
    h6c = LOCK ? 16'h1534 : 16'h95F4;

    // rst, we, addr, cdata, commit, flush, valid, sdata, ready, d, c, tv, fc
    tbl.push_back(mk(0,0,0,0,0,0,1,4'hA,0,16'h0000,16'h0000,0,0)); // IDLE: no shift
    tbl.push_back(mk(0,1,0,1,0,0,0,0,   0,16'h0000,16'h0000,0,0));
    tbl.push_back(mk(0,1,1,2,0,0,0,0,   0,16'h0000,16'h0000,0,0));
    tbl.push_back(mk(0,1,2,3,0,0,0,0,   0,16'h0000,16'h0000,0,0));
    tbl.push_back(mk(0,1,3,4,0,0,0,0,   0,16'h0000,16'h0000,0,0)); // shadow only
    tbl.push_back(mk(0,0,0,0,1,0,0,0,   0,16'h0000,16'h1234,0,0)); // commit -> FILL
    tbl.push_back(mk(0,0,0,0,0,0,1,5,   1,16'h5000,16'h1234,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,6,   1,16'h6500,16'h1234,0,2));
    tbl.push_back(mk(0,0,0,0,0,0,1,7,   1,16'h7650,16'h1234,0,3));
    tbl.push_back(mk(0,0,0,0,0,0,1,8,   1,16'h8765,16'h1234,1,4)); // full -> RUN
    tbl.push_back(mk(0,0,0,0,0,0,1,9,   1,16'h9876,16'h1234,1,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,4'hC,1,16'h9876,16'h1234,0,4)); // gap
    tbl.push_back(mk(0,0,0,0,0,0,1,4'hA,1,16'hA987,16'h1234,1,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,   1,16'hA987,16'h1234,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,   1,16'hA987,16'h1234,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,1,4'hB,1,16'hBA98,16'h1234,1,4));
    tbl.push_back(mk(0,0,0,0,0,1,1,4'hC,0,16'h0000,16'h1234,0,0)); // flush blocks accept
    tbl.push_back(mk(0,0,0,0,0,0,1,1,   1,16'h1000,16'h1234,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,2,   1,16'h2100,16'h1234,0,2));
    tbl.push_back(mk(0,0,0,0,0,0,1,3,   1,16'h3210,16'h1234,0,3));
    tbl.push_back(mk(0,0,0,0,0,0,1,4,   1,16'h4321,16'h1234,1,4)); // RUN again
    tbl.push_back(mk(0,1,2,4'hF,0,0,0,0,1,16'h4321,16'h1234,0,4)); // shadow write in RUN
    tbl.push_back(mk(0,0,0,0,1,0,0,0,   1,16'h4321,c22,     0,4)); // commit in RUN
    tbl.push_back(mk(0,1,0,7,1,0,0,0,   1,16'h4321,c22,     0,4)); // commit takes old shadow
    tbl.push_back(mk(0,0,0,0,1,0,0,0,   1,16'h4321,c24,     0,4));

    rst = 1'b1; coef_we = 0; coef_addr = 0; coef_data = 0; coef_commit = 0;
    flush = 0; s_valid = 0; s_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset d", {16'd0, d1, d2, d3, d4}, 32'd0);
    chk("reset c", {16'd0, c1, c2, c3, c4}, 32'd0);
    chk("reset taps_valid", {31'd0, taps_valid}, 32'd0);
    chk("reset fill_count", {29'd0, fill_count}, 32'd0);
    rst = 1'b0; s_valid = 1'b1;
    #1;
    chk("reset s_ready", {31'd0, s_ready}, 32'd0);

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], i);

    // Commit coincident with the completing accept, then flush+commit in RUN.
    apply(mk(0,0,0,0,0,1,0,0,   0,16'h0000,c24,0,0), 100);
    apply(mk(0,1,1,5,0,0,1,4'hD,1,16'hD000,c24,0,1), 101); // write in FILL
    apply(mk(0,0,0,0,0,0,1,4'hE,1,16'hED00,c24,0,2), 102);
    apply(mk(0,0,0,0,0,0,1,1,   1,16'h1ED0,c24,0,3), 103);
    apply(mk(0,0,0,0,1,0,1,2,   1,16'h21ED,h4c,1,4), 104); // new data + new coefs
    apply(mk(0,1,0,9,0,0,0,0,   1,16'h21ED,h4c,0,4), 105); // shadow write in RUN
    apply(mk(0,0,0,0,1,1,0,0,   0,16'h0000,h6c,0,0), 106); // flush + commit
    apply(mk(0,0,0,0,0,0,1,3,   1,16'h3000,h6c,0,1), 107); // back in FILL
    apply(mk(1,0,0,0,0,0,0,0,   1,16'h0000,16'h0000,0,0), 108); // mid-run reset
    apply(mk(0,0,0,0,0,0,1,5,   0,16'h0000,16'h0000,0,0), 109); // IDLE again

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
